// File: rtl/line_tool.sv
// Bresenham straight-line tool: a button press anchors the start point, the release
// fixes the end point, then one pixel of the line is streamed per clock.
module line_tool #(
  parameter  int WIDTH       = 640,
  parameter  int HEIGHT      = 480,
  parameter  int COLOR_WIDTH = 4,
  localparam int XW          = $clog2(WIDTH),
  localparam int YW          = $clog2(HEIGHT),
  localparam int AW          = ((XW > YW) ? XW : YW) + 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [XW-1:0]          cursor_x,
  input  logic [YW-1:0]          cursor_y,
  input  logic [COLOR_WIDTH-1:0] input_color,
  output logic [XW-1:0]          pixel_x,
  output logic [YW-1:0]          pixel_y,
  output logic [COLOR_WIDTH-1:0] pixel_color,
  output logic                   pixel_valid,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ANCHORED, DRAW} state_t;

  state_t                  state, state_nxt;
  logic                    enable_prev;
  logic                    rise, fall;

  logic [XW-1:0]           x0, x1, x;
  logic [YW-1:0]           y0, y1, y;
  logic [COLOR_WIDTH-1:0]  col;
  logic                    x_neg, y_neg;
  logic signed [AW-1:0]    dx, dy, err;

  logic signed [AW-1:0]    diff_x, diff_y, dx_init, dy_init;
  logic signed [AW-1:0]    e2, err_nxt;
  logic                    step_x, step_y, at_end;

  assign rise = enable & ~enable_prev;
  assign fall = ~enable & enable_prev;

  // Line setup from the anchored start point and the cursor at release
  always_comb begin
    diff_x  = signed'(AW'(cursor_x)) - signed'(AW'(x0));
    diff_y  = signed'(AW'(cursor_y)) - signed'(AW'(y0));
    dx_init = (diff_x < 0) ? -diff_x : diff_x;
    dy_init = (diff_y < 0) ? diff_y : -diff_y;
  end

  // Step decisions both use the pre-update error term
  always_comb begin
    e2      = err <<< 1;
    at_end  = (x == x1) && (y == y1);
    step_x  = (e2 >= dy);
    step_y  = (e2 <= dx);
    err_nxt = err + (step_x ? dy : '0) + (step_y ? dx : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      enable_prev <= 1'b0;
    end else begin
      state       <= state_nxt;
      enable_prev <= enable;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (rise)   state_nxt = ANCHORED;
      ANCHORED: if (fall)   state_nxt = DRAW;
      DRAW:     if (at_end) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DRAW) | pixel_valid;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && rise) begin
      x0 <= cursor_x;
      y0 <= cursor_y;
    end
    if (state == ANCHORED && fall) begin
      x1    <= cursor_x;
      y1    <= cursor_y;
      col   <= input_color;
      x     <= x0;
      y     <= y0;
      dx    <= dx_init;
      dy    <= dy_init;
      err   <= dx_init + dy_init;
      x_neg <= !(x0 < cursor_x);
      y_neg <= !(y0 < cursor_y);
    end else if (state == DRAW && !at_end) begin
      err <= err_nxt;
      if (step_x) x <= x_neg ? x - XW'(1) : x + XW'(1);
      if (step_y) y <= y_neg ? y - YW'(1) : y + YW'(1);
    end
  end

  // Output register: outputs hold their last value between lines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_color <= '0;
    end else begin
      pixel_valid <= (state == DRAW);
      if (state == DRAW) begin
        pixel_x     <= x;
        pixel_y     <= y;
        pixel_color <= col;
      end
    end
  end

endmodule

// File: tb/tb_line_tool.sv
// Directed bench for line_tool: each line is drawn by press/release and every
// emitted pixel is compared with a hand-computed list.
module tb_line_tool;

  localparam int XW = 10;
  localparam int YW = 9;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [XW-1:0] cursor_x = '0;
  logic [YW-1:0] cursor_y = '0;
  logic [CW-1:0] input_color = '0;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
  logic [CW-1:0] pixel_color;
  logic          pixel_valid;
  logic          busy;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_x[$];
  int exp_y[$];

  line_tool #(.WIDTH(640), .HEIGHT(480), .COLOR_WIDTH(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .input_color (input_color),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_color (pixel_color),
    .pixel_valid (pixel_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Draws (xa,ya)->(xb,yb) and checks it against exp_x/exp_y.
  // new_col >= 0 changes input_color after the first pixel; press_mid presses
  // the button during DRAW and releases it only after the line is done.
  task automatic run_line(input string tag, input int xa, input int ya,
                          input int xb, input int yb, input int col,
                          input int new_col, input bit press_mid);
    int n;
    n = exp_x.size();
    @(negedge clk);
    cursor_x = XW'(xa); cursor_y = YW'(ya); enable = 1'b1;
    @(negedge clk);
    cursor_x = XW'(xb); cursor_y = YW'(yb); input_color = CW'(col); enable = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_busy_start"}, int'(busy), 1);
    chk({tag, "_valid_start"}, int'(pixel_valid), 0);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s_valid%0d", tag, k), int'(pixel_valid), 1);
      chk($sformatf("%s_x%0d", tag, k), int'(pixel_x), exp_x[k]);
      chk($sformatf("%s_y%0d", tag, k), int'(pixel_y), exp_y[k]);
      chk($sformatf("%s_col%0d", tag, k), int'(pixel_color), col);
      chk($sformatf("%s_busy%0d", tag, k), int'(busy), 1);
      if (k == 0 && new_col >= 0) input_color = CW'(new_col);
      if (k == 1 && press_mid) enable = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, "_valid_end"}, int'(pixel_valid), 0);
    chk({tag, "_busy_end"}, int'(busy), 0);
    chk({tag, "_hold_x"}, int'(pixel_x), exp_x[n-1]);
    chk({tag, "_hold_y"}, int'(pixel_y), exp_y[n-1]);
    if (press_mid) begin
      repeat (2) @(posedge clk);
      #1 chk({tag, "_idle_held"}, int'(busy), 0);
      enable = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk({tag, "_idle_rel"}, int'(busy), 0);
      chk({tag, "_idle_valid"}, int'(pixel_valid), 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(pixel_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_x", int'(pixel_x), 0);
    chk("rst_y", int'(pixel_y), 0);
    chk("rst_col", int'(pixel_color), 0);
    @(negedge clk); reset = 1'b0;

    exp_x = '{2, 3, 4, 5, 6}; exp_y = '{3, 3, 3, 3, 3};
    run_line("horiz", 2, 3, 6, 3, 5, -1, 1'b0);

    exp_x = '{6, 5, 4, 3, 2}; exp_y = '{3, 3, 3, 3, 3};
    run_line("rev", 6, 3, 2, 3, 9, -1, 1'b0);

    exp_x = '{1, 1, 1, 1, 1}; exp_y = '{0, 1, 2, 3, 4};
    run_line("vert", 1, 0, 1, 4, 2, -1, 1'b0);

    exp_x = '{0, 1, 2, 3}; exp_y = '{0, 1, 2, 3};
    run_line("diag", 0, 0, 3, 3, 7, -1, 1'b0);

    exp_x = '{0, 1, 2, 3, 4}; exp_y = '{0, 1, 1, 2, 2};
    run_line("shallow", 0, 0, 4, 2, 3, -1, 1'b0);

    exp_x = '{7}; exp_y = '{7};
    run_line("degen", 7, 7, 7, 7, 12, -1, 1'b0);

    exp_x = '{5, 6, 7, 8, 9, 10}; exp_y = '{9, 8, 7, 6, 5, 4};
    run_line("colchg", 5, 9, 10, 4, 6, 11, 1'b0);

    exp_x = '{0, 1, 2, 3, 4, 5, 6, 7}; exp_y = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_line("igpress", 0, 0, 7, 0, 4, -1, 1'b1);

    exp_x = '{3, 4, 5}; exp_y = '{5, 5, 5};
    run_line("after_ig", 3, 5, 5, 5, 8, -1, 1'b0);

    // Abort a 10-pixel line after three pixels with an asynchronous reset
    @(negedge clk); cursor_x = 10'd0; cursor_y = 9'd0; enable = 1'b1;
    @(negedge clk); cursor_x = 10'd9; input_color = 4'd13; enable = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("abort_pre_valid", int'(pixel_valid), 1);
    chk("abort_pre_x", int'(pixel_x), 2);
    #2 reset = 1'b1;
    #1;
    chk("abort_valid", int'(pixel_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_x", int'(pixel_x), 0);
    chk("abort_y", int'(pixel_y), 0);
    chk("abort_col", int'(pixel_color), 0);
    @(posedge clk); #1;
    chk("abort_hold_valid", int'(pixel_valid), 0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("abort_idle_valid", int'(pixel_valid), 0);
    chk("abort_idle_busy", int'(busy), 0);

    exp_x = '{2, 1, 0}; exp_y = '{0, 1, 2};
    run_line("post_rst", 2, 0, 0, 2, 1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
